// File: rtl/kernel_launch_sched.sv
// Job FIFO plus launch FSM in front of one ap_start/ap_ready/ap_done kernel, reporting tag, run cycles and status.
// Optional run watchdog enabled by defining KERNEL_WATCHDOG_EN.
module kernel_launch_sched #(
    parameter int ARGS_W      = 16,
    parameter int ID_W        = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               job_valid,
    output logic                               job_ready,
    input  logic [ARGS_W-1:0]                  job_args,
    input  logic [ID_W-1:0]                    job_id,
    output logic                               ap_start,
    input  logic                               ap_ready,
    input  logic                               ap_done,
    output logic [ARGS_W-1:0]                  kernel_args,
    output logic                               kernel_rst,
    output logic                               cmpl_valid,
    input  logic                               cmpl_ready,
    output logic [ID_W-1:0]                    cmpl_id,
    output logic [CNT_W-1:0]                   cmpl_cycles,
    output logic                               cmpl_status,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   jobs_pending,
    output logic                               err_spurious_done
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OCC_W = $clog2(QUEUE_DEPTH+1);
`ifdef KERNEL_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);
    localparam logic [CNT_W-1:0] WDOG_LIM  = CNT_W'(WDOG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    state_t               state_q, state_d;
    logic [ARGS_W-1:0]    args_q [QUEUE_DEPTH];
    logic [ARGS_W-1:0]    args_d [QUEUE_DEPTH];
    logic [ID_W-1:0]      ids_q  [QUEUE_DEPTH];
    logic [ID_W-1:0]      ids_d  [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]     run_cnt_q, run_cnt_d, cycles_q, cycles_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic                 status_q, status_d, krst_q, krst_d, err_q, err_d;
    logic                 full, push, pop, wdog_hit;
    logic [CNT_W-1:0]     cnt_inc;

    assign full     = (occ_q == OCC_W'(QUEUE_DEPTH));
    assign push     = job_valid && !full;
    assign pop      = (state_q == LAUNCH) && ap_ready;
    assign cnt_inc  = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_W'(1);
    assign wdog_hit = WDOG_EN && (state_q == RUN) && (run_cnt_q == WDOG_LAST);

    // Job FIFO: no bypass, so a job always spends at least one cycle queued.
    always_comb begin
        args_d   = args_q;
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            args_d[wr_ptr_q] = job_args;
            ids_d[wr_ptr_q]  = job_id;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        cycles_d  = cycles_q;
        cur_id_d  = cur_id_q;
        status_d  = status_q;
        krst_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: if (occ_q != '0) state_d = LAUNCH;
            LAUNCH: if (ap_ready) begin
                cur_id_d  = ids_q[rd_ptr_q];
                run_cnt_d = '0;
                state_d   = RUN;
            end
            RUN: begin
                run_cnt_d = cnt_inc;
                // A done arriving on the watchdog's last cycle still counts as a normal finish.
                if (ap_done) begin
                    cycles_d = cnt_inc;
                    status_d = 1'b0;
                    state_d  = REPORT;
                end else if (wdog_hit) begin
                    cycles_d = WDOG_LIM;
                    status_d = 1'b1;
                    krst_d   = 1'b1;
                    state_d  = REPORT;
                end
            end
            REPORT: if (cmpl_ready) state_d = (occ_q != '0) ? LAUNCH : IDLE;
            default: state_d = IDLE;
        endcase
        if (ap_done && (state_q != RUN)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                args_q[i] <= '0;
                ids_q[i]  <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            run_cnt_q <= '0;
            cycles_q  <= '0;
            cur_id_q  <= '0;
            status_q  <= 1'b0;
            krst_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            args_q    <= args_d;
            ids_q     <= ids_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            run_cnt_q <= run_cnt_d;
            cycles_q  <= cycles_d;
            cur_id_q  <= cur_id_d;
            status_q  <= status_d;
            krst_q    <= krst_d;
            err_q     <= err_d;
        end
    end

    assign job_ready         = !full;
    assign ap_start          = (state_q == LAUNCH);
    assign kernel_args       = args_q[rd_ptr_q];
    assign kernel_rst        = krst_q;
    assign cmpl_valid        = (state_q == REPORT);
    assign cmpl_id           = cur_id_q;
    assign cmpl_cycles       = cycles_q;
    assign cmpl_status       = status_q;
    assign busy              = (state_q != IDLE);
    assign jobs_pending      = occ_q;
    assign err_spurious_done = err_q;
endmodule

// File: doc/kernel_launch_sched.md
Name: kernel_launch_sched

Overview:
- Job scheduler in front of one handshake-kernel top wrapper (ap_start/ap_ready/ap_done plus scalar argument inputs).
- Queues up to QUEUE_DEPTH invocation requests, each carrying packed scalar arguments and a tag, and launches them one at a time.
- After each run it reports a completion record with the tag, the measured run cycles and a status code.
- Sits between the host/testbench job stream and the kernel top; the kernel's own memory interfaces bypass this block.

Parameters:
- ARGS_W, 16, packed scalar-argument width (e.g. {beta, alpha}, 8 bits each)
- ID_W, 4, job tag width
- QUEUE_DEPTH, 4, job FIFO entries; power of two, at least 2
- CNT_W, 16, cycle-counter width
- WDOG_CYCLES, 1000, watchdog limit in run cycles; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when valid&ready
- job_args  in  ARGS_W  packed arguments
- job_id  in  ID_W  job tag
- ap_start  out  1  kernel start request
- ap_ready  in  1  kernel idle; start taken when ap_start&ap_ready
- ap_done  in  1  kernel finished; one-cycle pulse
- kernel_args  out  ARGS_W  arguments of the job being launched
- kernel_rst  out  1  one-cycle kernel reset pulse (watchdog only)
- cmpl_valid  out  1  completion record valid
- cmpl_ready  in  1  completion consumed
- cmpl_id  out  ID_W  tag of the completed job
- cmpl_cycles  out  CNT_W  run cycles
- cmpl_status  out  1  0 = done, 1 = timeout
- busy  out  1  state != IDLE
- jobs_pending  out  clog2(QUEUE_DEPTH+1)  FIFO occupancy
- err_spurious_done  out  1  sticky: ap_done seen outside RUN

Behaviour:
- Reset values: state IDLE, FIFO empty, counter 0. All outputs 0 except job_ready = 1. err_spurious_done is cleared only by rst.
- FIFO:
  - job_ready = !full. Push on job_valid&job_ready; pop on launch accept.
  - No bypass. Push and pop may occur in the same cycle when the FIFO is not full.
  - Pointers wrap modulo QUEUE_DEPTH. jobs_pending is updated on the cycle after the push/pop.
- FSM states: IDLE, LAUNCH, RUN, REPORT.
- IDLE: if jobs_pending != 0, go to LAUNCH next cycle.
- LAUNCH:
  - ap_start = 1 and kernel_args = FIFO head, both held stable until ap_start&ap_ready.
  - In that accept cycle: pop, latch the head id, clear the counter, go to RUN.
- RUN:
  - Counter increments each cycle and saturates at all-ones.
  - On ap_done: cmpl_cycles = counter+1 (saturating), so it counts cycles from after the accept cycle through the ap_done cycle inclusive. cmpl_status = 0; go to REPORT.
- REPORT:
  - cmpl_valid = 1; cmpl_id, cmpl_cycles and cmpl_status are held stable.
  - On cmpl_ready: go to LAUNCH if jobs_pending != 0, else IDLE.
- Latency: job accepted at cycle t into an idle, empty block gives ap_start high at t+2. If ap_ready = 1 at t+2, RUN starts at t+3.
- ap_done while in IDLE, LAUNCH or REPORT is ignored for sequencing and sets err_spurious_done.
- ap_done in the same cycle as the launch accept is treated as spurious.
- Outputs are driven from registered state/data only, apart from the documented handshake pass-through (job_ready from full).
- rst mid-run: the FIFO is flushed and any in-flight job is dropped with no completion record.

Optional Feature:
- Macro: KERNEL_WATCHDOG_EN.
- Defined:
  - In RUN, when the counter reaches WDOG_CYCLES-1 without ap_done: go to REPORT with cmpl_status = 1 and cmpl_cycles = WDOG_CYCLES.
  - kernel_rst pulses high for exactly one cycle, on the transition into REPORT.
  - ap_done arriving in that same cycle wins: status 0, no kernel_rst.
- Undefined: kernel_rst tied 0, cmpl_status always 0, WDOG_CYCLES ignored.

Test Plan:
- Single job: args=0x0302, id=5; ap_ready=1; ap_done 10 cycles after the accept -> ap_start at t+2, kernel_args=0x0302, one completion with id=5, cycles=10, status=0.
- Queue fill: 5 jobs back-to-back with the kernel held busy (ap_ready=0) -> job_ready low after the 4th, jobs_pending=4; completions come out in order with ids 0..3 and then 4.
- Backpressure: cmpl_ready=0 for 20 cycles -> cmpl_valid and all cmpl fields stable; no new ap_start until the record is consumed; next launch on the cycle after cmpl_ready.
- Spurious done: ap_done pulse while IDLE -> err_spurious_done=1 and held; state stays IDLE.
- Reset mid-run: rst during RUN with 2 jobs queued -> jobs_pending=0, busy=0, no cmpl_valid afterwards.
- Watchdog (KERNEL_WATCHDOG_EN, WDOG_CYCLES=50): no ap_done -> status=1, cycles=50, one kernel_rst pulse; without the macro the bench waits indefinitely with no completion.
